// File: rtl/jk_pkg.sv
// Shared JK flip-flop command encodings and the excitation helper used by the
// structural counter.
package jk_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

  // {J,K} that moves a cell from cur to nxt without relying on toggle.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    logic [1:0] jk;
    jk[1] = ~cur & nxt;
    jk[0] = cur & ~nxt;
    return jk;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      unique case ({j, k})
        HOLD: q_q <= q_q;
        RST:  q_q <= 1'b0;
        SET:  q_q <= 1'b1;
        TGL:  q_q <= ~q_q;
      endcase
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built from JK cells; the next state is chosen by a
// priority mux and translated into per-cell J/K excitation.
module jk_mod_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  import jk_pkg::*;

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic             wrap_d;
  logic             wrap_q;

  // Priority: load (clamped), wrap constant, increment, decrement, hold.
  always_comb begin
    n      = q;
    wrap_d = 1'b0;
    if (load) begin
      n = (d > MaxVal) ? '0 : d;
    end else if (en) begin
      if (up && (q == MaxVal)) begin
        n      = '0;
        wrap_d = 1'b1;
      end else if (!up && (q == '0)) begin
        n      = MaxVal;
        wrap_d = 1'b1;
      end else if (up) begin
        n = q + WIDTH'(1);
      end else begin
        n = q - WIDTH'(1);
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic [1:0] jk;
    assign jk        = jk_excite(q[i], n[i]);
    assign cell_j[i] = jk[1];
    assign cell_k[i] = jk[0];

    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (cell_j[i]),
      .k    (cell_k[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;
  assign tc   = up ? (q == MaxVal) : (q == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a decade counter (4-bit, MOD 10) and a full-range
// 3-bit counter driven in lockstep and compared against an arithmetic model.
module tb_jk_mod_counter;

  logic       clk;
  logic       reset, en, up, load;
  logic [3:0] d;
  logic [3:0] q, qbar;
  logic       tc, wrap;
  logic [2:0] q8, qbar8;
  logic       tc8, wrap8;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int m_q, m8_q;
  bit m_wrap, m8_wrap;

  jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d),
    .q(q), .qbar(qbar), .tc(tc), .wrap(wrap)
  );

  jk_mod_counter #(.WIDTH(3), .MOD(8)) dut8 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .d(d[2:0]),
    .q(q8), .qbar(qbar8), .tc(tc8), .wrap(wrap8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behaviour of a modulo counter stated directly in arithmetic.
  function automatic void step(input int mod, input int cur, input int dv, input bit r,
                               input bit l, input bit e, input bit u,
                               output int nq, output bit nw);
    nw = 1'b0;
    if (r) nq = 0;
    else if (l) nq = (dv < mod) ? dv : 0;
    else if (e && u) begin
      nq = (cur + 1) % mod;
      nw = (cur == mod - 1);
    end else if (e) begin
      nq = (cur + mod - 1) % mod;
      nw = (cur == 0);
    end else nq = cur;
  endfunction

  always @(posedge clk) begin : model
    int nq, nq8;
    bit nw, nw8;
    step(10, m_q, int'(d), reset, load, en, up, nq, nw);
    step(8, m8_q, int'(d[2:0]), reset, load, en, up, nq8, nw8);
    m_q     <= nq;
    m_wrap  <= nw;
    m8_q    <= nq8;
    m8_wrap <= nw8;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("q", int'(q), m_q);
      chk("qbar", int'(qbar), m_q ^ 15);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("tc", int'(tc), up ? int'(m_q == 9) : int'(m_q == 0));
      chk("q8", int'(q8), m8_q);
      chk("qbar8", int'(qbar8), m8_q ^ 7);
      chk("wrap8", int'(wrap8), int'(m8_wrap));
      chk("tc8", int'(tc8), up ? int'(m8_q == 7) : int'(m8_q == 0));
      if (!reset && !load && !en) begin
        chk("hold_j", int'(dut.cell_j), 0);
        chk("hold_k", int'(dut.cell_k), 0);
      end
    end
  end

  task automatic apply(input bit r, input bit e, input bit u, input bit l, input int dv);
    reset = r;
    en    = e;
    up    = u;
    load  = l;
    d     = 4'(dv);
    @(posedge clk);
    #1;
  endtask

  int down_exp [4] = '{1, 0, 9, 8};
  int full_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};

  initial begin
    reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    apply(1, 0, 1, 0, 0);
    apply(1, 0, 1, 0, 0);
    chk_on = 1'b1;
    chk("rst_q", int'(q), 0);
    chk("rst_qbar", int'(qbar), 15);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_tc_up", int'(tc), 0);
    up = 1'b0;
    #1;
    chk("rst_tc_down", int'(tc), 1);

    // Up count through the wrap.
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 1, 0, 0);
      chk("up_q", int'(q), (i + 1) % 10);
      chk("up_wrap", int'(wrap), int'(i == 9));
    end
    chk("up_end_model", m_q, 2);

    // Down count through the wrap.
    apply(0, 0, 0, 1, 2);
    chk("load2", int'(q), 2);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 0, 0);
      chk("down_q", int'(q), down_exp[i]);
      chk("down_wrap", int'(wrap), int'(i == 2));
      chk("down_tc", int'(tc), int'(i == 1));
    end

    // Loads, clamp, and load beating enable at the boundary.
    apply(0, 0, 1, 1, 7);
    chk("load7", int'(q), 7);
    apply(0, 0, 1, 1, 13);
    chk("load13", int'(q), 0);
    chk("load13_w3", int'(q8), 5);
    apply(0, 0, 1, 1, 9);
    apply(0, 1, 1, 1, 4);
    chk("load_en_q", int'(q), 4);
    chk("load_en_wrap", int'(wrap), 0);

    // Reset mid-count, then hold.
    apply(0, 1, 1, 0, 0);
    chk("at5", int'(q), 5);
    apply(1, 1, 1, 0, 0);
    chk("mid_reset", int'(q), 0);
    apply(0, 1, 1, 0, 0);
    apply(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 1, 0, 0);
      chk("hold_q", int'(q), 2);
      chk("hold_wrap", int'(wrap), 0);
    end

    // Full binary range on the 3-bit instance.
    apply(1, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      apply(0, 1, 1, 0, 0);
      chk("full_q", int'(q8), full_exp[i]);
      chk("full_wrap", int'(wrap8), int'(i == 7));
    end
    apply(0, 0, 1, 1, 7);
    chk("full_load7", int'(q8), 7);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            ($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
# jk_mod_counter

Synchronous modulo-MOD up/down counter built from JK flip-flop cells, with the J/K inputs of every cell chosen by multiplexed excitation logic rather than by a behavioural adder. This is the structural counter that the JK flip-flop cell feeds. It adds the following to the cell's hold/set/reset/toggle behaviour:

- count direction
- parallel load
- enable
- terminal-count and wrap indications

## Interface

Parameters:

- WIDTH, 4, state width in bits; must satisfy 2^WIDTH >= MOD
- MOD, 10, count modulus; legal values 2..2^WIDTH; the counting range is 0..MOD-1

Ports (one clock; reset is synchronous and active-high):

- clk, input, 1, rising-edge clock
- reset, input, 1, synchronous active-high reset
- en, input, 1, count enable
- up, input, 1, direction: 1 counts up, 0 counts down
- load, input, 1, parallel load strobe
- d, input, WIDTH, parallel load value
- q, output, WIDTH, registered count
- qbar, output, WIDTH, bitwise complement of q, taken from the cells
- tc, output, 1, combinational terminal count
- wrap, output, 1, registered one-cycle pulse

## Operation

- Priority at each rising edge of clk: reset > load > en > hold.
- reset: q=0 and wrap=0 on that edge.
- load: q takes the value d when d <= MOD-1. If d >= MOD, q=0. Load never raises wrap.
- Count up (en=1, up=1): q = q+1. When q = MOD-1, the next value is 0.
- Count down (en=1, up=0): q = q-1. When q = 0, the next value is MOD-1.
- Hold (en=0 and load=0): q is unchanged and wrap=0.
- Excitation: the controller computes the next state n and drives each cell i with J_i = ~q_i & n_i and K_i = q_i & ~n_i.
  - The n source is selected by a mux with these inputs, in priority order: load value, wrap constant (0 or MOD-1), incremented q, decremented q, q itself (hold).
  - In hold, every cell sees J=K=0.
- tc = (up & q==MOD-1) | (~up & q==0). It is independent of en and follows up combinationally.
- wrap = 1 on the cycle after any edge on which a count (not a load) moved q across the boundary (MOD-1 to 0, or 0 to MOD-1). It is 0 otherwise.
- Out-of-range state cannot occur. q is only written from reset, a clamped load, or legal counting.

## Timing

- Counting and load latency is one cycle: q updates on the rising edge where the command is sampled.
- wrap asserts in the same cycle that q shows the wrapped value, and lasts exactly one cycle.
- Reset values: q=0, qbar={WIDTH{1}}, wrap=0. During reset, tc = ~up.
- Reset asserted during counting or a load takes effect on that same edge. Nothing from the command is retained.
- Simultaneous load and en: load wins, and wrap=0 on the next cycle.
- Direction change while at a boundary: tc re-evaluates immediately. The wrap decision uses the up value sampled on the edge.
- MOD = 2^WIDTH is legal. Wrap is then the natural binary rollover, and the clamp never triggers.

## Structure

- Shared package jk_pkg holds:
  - the JK command constants (HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11)
  - a function that returns the {J,K} pair for a (current, next) bit pair
- Sub-module jk_cell: a single JK flip-flop with ports clk, reset, j, k, q, qbar.
  - Synchronous active-high reset to q=0.
  - 00 holds, 01 clears, 10 sets, 11 toggles.
- jk_mod_counter instantiates WIDTH copies of jk_cell through a generate loop. It also contains the next-state mux, the clamp logic, the tc logic and the wrap register.

## Test plan

Parameters are WIDTH=4, MOD=10 unless stated otherwise.

- Reset: assert reset for 2 cycles with up=1 -> q=0, qbar=4'hF, wrap=0, tc=0. Drive up=0 -> tc=1 combinationally.
- Up count with wrap: en=1, up=1, 12 cycles -> q runs 1..9 then 0,1,2. tc=1 while q=9. wrap=1 only in the cycle with q=0.
- Down count with wrap: load d=2, then en=1, up=0 -> q runs 1,0,9,8. tc=1 while q=0. wrap=1 in the cycle with q=9.
- Load: load d=7 gives q=7. Load d=13 gives q=0. Load=1 together with en=1 at q=9 with up=1 gives q=d and wrap=0.
- Mid-operation events:
  - At q=5 while counting up, reset=1 for one cycle -> q=0 on the next edge.
  - en=0 for 3 cycles -> q held, every cell sees J=K=0, wrap=0.
- Full binary range: WIDTH=3, MOD=8, up count for 9 cycles -> q runs 1..7, 0, 1. wrap=1 at q=0. No clamp is applied to a load of d=7.
